// File: rtl/sp_line_shifter.sv
// -----------------------------------------------------------------------------
// sp_line_shifter
//
// Sequential sprite pixel engine for the PPU. Holds NUM_SLOTS sprite slots,
// each with an X down-counter and a pair of pattern shift registers. Slots are
// written one per cycle from secondary OAM during the HBlank sprite fetch. On
// every visible dot (pix_en) the engine resolves priority across the slots
// and registers one sprite pixel for the background/sprite mux.
//
// Ports
//   clk           PPU dot clock
//   rst           synchronous active-high reset
//   load_en       write one slot this cycle
//   load_slot     slot index to write (indices >= NUM_SLOTS are ignored)
//   load_valid    entry is a real sprite (0 leaves the slot inactive)
//   load_x        sprite X position
//   load_attr     OAM attribute byte: [1:0] palette, [5] priority, [6] hflip
//   load_lo/hi    pattern bitplanes
//   load_zero     slot holds OAM sprite 0
//   line_start    next visible dot is dot 0
//   pix_en        advance one visible dot
//   show_left     show sprites in columns 0..7
//   sp_enable     sprite rendering enable
//   sp_color_idx  {palette, color}; 0 is transparent
//   sp_prio       priority bit of the winning slot
//   sp_zero       winning opaque pixel came from sprite 0
//   sp_valid      outputs belong to the previous pix_en
// -----------------------------------------------------------------------------
module sp_line_shifter #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic              load_valid,
    input  logic [7:0]        load_x,
    input  logic [7:0]        load_attr,
    input  logic [7:0]        load_lo,
    input  logic [7:0]        load_hi,
    input  logic              load_zero,
    input  logic              line_start,
    input  logic              pix_en,
    input  logic              show_left,
    input  logic              sp_enable,
    output logic [3:0]        sp_color_idx,
    output logic              sp_prio,
    output logic              sp_zero,
    output logic              sp_valid
);

    // Horizontal flip is applied once at load time so the shifters always
    // present the next pixel on bit 7.
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k] = b[7-k];
        end
        return r;
    endfunction

    // Per-slot state
    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [7:0]           xcnt_q  [NUM_SLOTS];
    logic [7:0]           xcnt_d  [NUM_SLOTS];
    logic [7:0]           sh_lo_q [NUM_SLOTS];
    logic [7:0]           sh_lo_d [NUM_SLOTS];
    logic [7:0]           sh_hi_q [NUM_SLOTS];
    logic [7:0]           sh_hi_d [NUM_SLOTS];
    logic [3:0]           pcnt_q  [NUM_SLOTS];
    logic [3:0]           pcnt_d  [NUM_SLOTS];
    logic [1:0]           pal_q   [NUM_SLOTS];
    logic [1:0]           pal_d   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] prio_q, prio_d;
    logic [NUM_SLOTS-1:0] zero_q, zero_d;

    // Line position and registered outputs
    logic [8:0] dotcnt_q, dotcnt_d;
    logic [3:0] color_q, color_d;
    logic       prio_out_q, prio_out_d;
    logic       zero_out_q, zero_out_d;
    logic       valid_q;

    logic [NUM_SLOTS-1:0] hit;
    logic [NUM_SLOTS-1:0] emit;
    logic [8:0]           dot_now;
    logic                 masked;
    logic [3:0]           win_col;
    logic                 win_prio;
    logic                 win_zero;

    // Attribute bits not used by the pixel engine (vertical flip is resolved
    // during the pattern fetch, bits 4:2 are unimplemented in OAM).
    logic unused_attr;
    assign unused_attr = ^{load_attr[7], load_attr[4:2]};

    // Slot load / dot advance
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active_d[i] = active_q[i];
            xcnt_d[i]   = xcnt_q[i];
            sh_lo_d[i]  = sh_lo_q[i];
            sh_hi_d[i]  = sh_hi_q[i];
            pcnt_d[i]   = pcnt_q[i];
            pal_d[i]    = pal_q[i];
            prio_d[i]   = prio_q[i];
            zero_d[i]   = zero_q[i];

            // A slot written this cycle neither emits nor shifts.
            hit[i]  = load_en && (load_slot == SLOT_W'(i));
            emit[i] = active_q[i] && !hit[i] && (xcnt_q[i] == 8'd0) && !pcnt_q[i][3];

            if (hit[i]) begin
                active_d[i] = load_valid;
                xcnt_d[i]   = load_x;
                pcnt_d[i]   = 4'd0;
                pal_d[i]    = load_attr[1:0];
                prio_d[i]   = load_attr[5];
                zero_d[i]   = load_zero;
                sh_lo_d[i]  = load_attr[6] ? rev8(load_lo) : load_lo;
                sh_hi_d[i]  = load_attr[6] ? rev8(load_hi) : load_hi;
            end else if (pix_en && active_q[i]) begin
                if (xcnt_q[i] != 8'd0) begin
                    xcnt_d[i] = xcnt_q[i] - 8'd1;
                end else if (!pcnt_q[i][3]) begin
                    sh_lo_d[i] = {sh_lo_q[i][6:0], 1'b0};
                    sh_hi_d[i] = {sh_hi_q[i][6:0], 1'b0};
                    pcnt_d[i]  = pcnt_q[i] + 4'd1;
                    // Retire the slot as its eighth pixel goes out.
                    if (pcnt_q[i] == 4'd7) begin
                        active_d[i] = 1'b0;
                    end
                end else begin
                    active_d[i] = 1'b0;
                end
            end
        end
    end

    // Priority: walk from the highest index down so the lowest-index opaque
    // emitting slot is the last to write and therefore wins.
    always_comb begin
        win_col  = 4'd0;
        win_prio = 1'b0;
        win_zero = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (emit[i] && (sh_hi_q[i][7] || sh_lo_q[i][7])) begin
                win_col  = {pal_q[i], sh_hi_q[i][7], sh_lo_q[i][7]};
                win_prio = prio_q[i];
                win_zero = zero_q[i];
            end
        end
    end

    // Dot counter, left-column clip and output staging
    always_comb begin
        // line_start together with pix_en is dot 0 of the new line.
        dot_now  = line_start ? 9'd0 : dotcnt_q;
        dotcnt_d = dotcnt_q;
        if (line_start) begin
            dotcnt_d = pix_en ? 9'd1 : 9'd0;
        end else if (pix_en) begin
            dotcnt_d = dotcnt_q + 9'd1;
        end

        masked = !sp_enable || (!show_left && (dot_now < 9'd8));

        color_d    = color_q;
        prio_out_d = prio_out_q;
        zero_out_d = zero_out_q;
        if (pix_en) begin
            color_d    = masked ? 4'd0 : win_col;
            prio_out_d = masked ? 1'b0 : win_prio;
            zero_out_d = masked ? 1'b0 : win_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= '0;
            prio_q     <= '0;
            zero_q     <= '0;
            dotcnt_q   <= 9'd0;
            color_q    <= 4'd0;
            prio_out_q <= 1'b0;
            zero_out_q <= 1'b0;
            valid_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                xcnt_q[i]  <= 8'd0;
                sh_lo_q[i] <= 8'd0;
                sh_hi_q[i] <= 8'd0;
                pcnt_q[i]  <= 4'd0;
                pal_q[i]   <= 2'd0;
            end
        end else begin
            active_q   <= active_d;
            prio_q     <= prio_d;
            zero_q     <= zero_d;
            dotcnt_q   <= dotcnt_d;
            color_q    <= color_d;
            prio_out_q <= prio_out_d;
            zero_out_q <= zero_out_d;
            valid_q    <= pix_en;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                xcnt_q[i]  <= xcnt_d[i];
                sh_lo_q[i] <= sh_lo_d[i];
                sh_hi_q[i] <= sh_hi_d[i];
                pcnt_q[i]  <= pcnt_d[i];
                pal_q[i]   <= pal_d[i];
            end
        end
    end

    assign sp_color_idx = color_q;
    assign sp_prio      = prio_out_q;
    assign sp_zero      = zero_out_q;
    assign sp_valid     = valid_q;

endmodule

// File: tb/tb_sp_line_shifter.sv
// -----------------------------------------------------------------------------
// tb_sp_line_shifter
//
// Directed bench for sp_line_shifter: an 8-slot instance for the main
// scenarios and a 16-slot instance for the no-flicker slot count.
// -----------------------------------------------------------------------------
module tb_sp_line_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_en = 1'b0;
    logic [2:0] load_slot = 3'd0;
    logic       load_en16 = 1'b0;
    logic [3:0] load_slot16 = 4'd0;
    logic       load_valid = 1'b0;
    logic [7:0] load_x = 8'd0;
    logic [7:0] load_attr = 8'd0;
    logic [7:0] load_lo = 8'd0;
    logic [7:0] load_hi = 8'd0;
    logic       load_zero = 1'b0;
    logic       line_start = 1'b0;
    logic       pix_en = 1'b0;
    logic       show_left = 1'b1;
    logic       sp_enable = 1'b1;

    logic [3:0] sp_color_idx, c16;
    logic       sp_prio, sp_zero, sp_valid;
    logic       p16, z16, v16;

    int total = 0;
    int bad   = 0;

    logic [3:0] gc [256];
    logic       gp [256];
    logic       gz [256];
    logic       gv [256];
    logic [3:0] g16 [256];

    always #5 clk = ~clk;

    sp_line_shifter #(.NUM_SLOTS(8)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_slot(load_slot),
        .load_valid(load_valid), .load_x(load_x), .load_attr(load_attr),
        .load_lo(load_lo), .load_hi(load_hi), .load_zero(load_zero),
        .line_start(line_start), .pix_en(pix_en), .show_left(show_left),
        .sp_enable(sp_enable), .sp_color_idx(sp_color_idx), .sp_prio(sp_prio),
        .sp_zero(sp_zero), .sp_valid(sp_valid)
    );

    sp_line_shifter #(.NUM_SLOTS(16)) dut16 (
        .clk(clk), .rst(rst), .load_en(load_en16), .load_slot(load_slot16),
        .load_valid(load_valid), .load_x(load_x), .load_attr(load_attr),
        .load_lo(load_lo), .load_hi(load_hi), .load_zero(load_zero),
        .line_start(line_start), .pix_en(pix_en), .show_left(show_left),
        .sp_enable(sp_enable), .sp_color_idx(c16), .sp_prio(p16),
        .sp_zero(z16), .sp_valid(v16)
    );

    initial begin
        #1000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int slot, input bit big, input logic [7:0] x,
                        input logic [7:0] attr, input logic [7:0] lo,
                        input logic [7:0] hi, input logic zero);
        load_valid = 1'b1;
        load_x     = x;
        load_attr  = attr;
        load_lo    = lo;
        load_hi    = hi;
        load_zero  = zero;
        if (big) begin
            load_en16   = 1'b1;
            load_slot16 = 4'(slot);
        end else begin
            load_en   = 1'b1;
            load_slot = 3'(slot);
        end
        tick();
        load_en   = 1'b0;
        load_en16 = 1'b0;
    endtask

    task automatic run_line();
        for (int d = 0; d < 256; d++) begin
            line_start = (d == 0);
            pix_en     = 1'b1;
            tick();
            gc[d]  = sp_color_idx;
            gp[d]  = sp_prio;
            gz[d]  = sp_zero;
            gv[d]  = sp_valid;
            g16[d] = c16;
        end
        line_start = 1'b0;
        pix_en     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (sp_color_idx !== 4'd0) begin bad++; $display("FAIL reset_color got=%h exp=0", sp_color_idx); end
        total++; if (sp_prio !== 1'b0) begin bad++; $display("FAIL reset_prio got=%b exp=0", sp_prio); end
        total++; if (sp_zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", sp_zero); end
        total++; if (sp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sp_valid); end
        tick();
        total++; if (sp_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", sp_valid); end
    endtask

    task automatic test_single();
        logic [3:0] e;
        do_reset();
        load(0, 1'b0, 8'd10, 8'h02, 8'h80, 8'h00, 1'b0);
        run_line();
        for (int d = 0; d < 256; d++) begin
            e = (d == 10) ? 4'h9 : 4'h0;
            total++; if (gc[d] !== e) begin bad++; $display("FAIL single_color dot=%0d got=%h exp=%h", d, gc[d], e); end
            total++; if (gv[d] !== 1'b1) begin bad++; $display("FAIL single_valid dot=%0d got=%b exp=1", d, gv[d]); end
        end
        tick();
        total++; if (sp_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after got=%b exp=0", sp_valid); end
    endtask

    task automatic test_flip();
        logic [3:0] e;
        do_reset();
        load(3, 1'b0, 8'd0, 8'h41, 8'h01, 8'h01, 1'b0);
        run_line();
        for (int d = 0; d < 16; d++) begin
            e = (d == 0) ? 4'h7 : 4'h0;
            total++; if (gc[d] !== e) begin bad++; $display("FAIL flip_on dot=%0d got=%h exp=%h", d, gc[d], e); end
        end
        do_reset();
        load(3, 1'b0, 8'd0, 8'h01, 8'h01, 8'h01, 1'b0);
        run_line();
        for (int d = 0; d < 16; d++) begin
            e = (d == 7) ? 4'h7 : 4'h0;
            total++; if (gc[d] !== e) begin bad++; $display("FAIL flip_off dot=%0d got=%h exp=%h", d, gc[d], e); end
        end
    endtask

    task automatic test_priority();
        logic [3:0] e;
        logic       ep;
        do_reset();
        load(1, 1'b0, 8'd20, 8'h01, 8'hFF, 8'h00, 1'b0);
        load(0, 1'b0, 8'd20, 8'h23, 8'h0F, 8'h00, 1'b0);
        run_line();
        for (int d = 16; d < 32; d++) begin
            e  = (d >= 20 && d <= 23) ? 4'h5 : (d >= 24 && d <= 27) ? 4'hD : 4'h0;
            ep = (d >= 24 && d <= 27);
            total++; if (gc[d] !== e) begin bad++; $display("FAIL prio_color dot=%0d got=%h exp=%h", d, gc[d], e); end
            total++; if (gp[d] !== ep) begin bad++; $display("FAIL prio_bit dot=%0d got=%b exp=%b", d, gp[d], ep); end
        end
    endtask

    task automatic test_zero_clip();
        logic [3:0] e;
        logic       ez;
        do_reset();
        show_left = 1'b0;
        load(2, 1'b0, 8'd4, 8'h00, 8'hFF, 8'h00, 1'b1);
        run_line();
        for (int d = 0; d < 16; d++) begin
            ez = (d >= 8 && d <= 11);
            e  = ez ? 4'h1 : 4'h0;
            total++; if (gc[d] !== e) begin bad++; $display("FAIL clip_color dot=%0d got=%h exp=%h", d, gc[d], e); end
            total++; if (gz[d] !== ez) begin bad++; $display("FAIL clip_zero dot=%0d got=%b exp=%b", d, gz[d], ez); end
        end
        show_left = 1'b1;
        do_reset();
        load(2, 1'b0, 8'd4, 8'h00, 8'hFF, 8'h00, 1'b1);
        run_line();
        for (int d = 0; d < 16; d++) begin
            ez = (d >= 4 && d <= 11);
            e  = ez ? 4'h1 : 4'h0;
            total++; if (gc[d] !== e) begin bad++; $display("FAIL show_color dot=%0d got=%h exp=%h", d, gc[d], e); end
            total++; if (gz[d] !== ez) begin bad++; $display("FAIL show_zero dot=%0d got=%b exp=%b", d, gz[d], ez); end
        end
    endtask

    task automatic test_sp_disable();
        do_reset();
        sp_enable = 1'b0;
        load(0, 1'b0, 8'd0, 8'h03, 8'hFF, 8'hFF, 1'b1);
        run_line();
        sp_enable = 1'b1;
        for (int d = 0; d < 12; d++) begin
            total++; if (gc[d] !== 4'h0) begin bad++; $display("FAIL disable_color dot=%0d got=%h exp=0", d, gc[d]); end
            total++; if (gz[d] !== 1'b0) begin bad++; $display("FAIL disable_zero dot=%0d got=%b exp=0", d, gz[d]); end
        end
    endtask

    task automatic test_truncation();
        logic [3:0] e;
        do_reset();
        load(0, 1'b0, 8'd252, 8'h00, 8'hFF, 8'h00, 1'b0);
        run_line();
        for (int d = 0; d < 256; d++) begin
            e = (d >= 252) ? 4'h1 : 4'h0;
            total++; if (gc[d] !== e) begin bad++; $display("FAIL trunc dot=%0d got=%h exp=%h", d, gc[d], e); end
        end
        // Output holds while pix_en is low; valid drops.
        tick();
        total++; if (sp_color_idx !== 4'h1) begin bad++; $display("FAIL hold_color got=%h exp=1", sp_color_idx); end
        total++; if (sp_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b exp=0", sp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        do_reset();
        load(0, 1'b0, 8'd3, 8'h00, 8'hFF, 8'h00, 1'b0);
        for (int d = 0; d < 20; d++) begin
            line_start = (d == 0);
            pix_en     = 1'b1;
            if (d == 2) begin
                load_en    = 1'b1;
                load_slot  = 3'd1;
                load_valid = 1'b1;
                load_x     = 8'd2;
                load_attr  = 8'h02;
                load_lo    = 8'hFF;
                load_hi    = 8'hFF;
                load_zero  = 1'b0;
            end
            tick();
            load_en = 1'b0;
            gc[d]   = sp_color_idx;
        end
        line_start = 1'b0;
        pix_en     = 1'b0;
        for (int d = 0; d < 20; d++) begin
            e = (d >= 3 && d <= 10) ? 4'h1 : (d == 11 || d == 12) ? 4'hB : 4'h0;
            total++; if (gc[d] !== e) begin bad++; $display("FAIL collide dot=%0d got=%h exp=%h", d, gc[d], e); end
        end
    endtask

    task automatic test_reset_midline();
        logic [3:0] e;
        do_reset();
        load(0, 1'b0, 8'd12, 8'h00, 8'hFF, 8'h00, 1'b0);
        for (int d = 0; d < 15; d++) begin
            line_start = (d == 0);
            pix_en     = 1'b1;
            tick();
            e = (d >= 12) ? 4'h1 : 4'h0;
            total++; if (sp_color_idx !== e) begin bad++; $display("FAIL midrst_pre dot=%0d got=%h exp=%h", d, sp_color_idx, e); end
        end
        line_start = 1'b0;
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        pix_en = 1'b0;
        total++; if (sp_color_idx !== 4'h0) begin bad++; $display("FAIL midrst_color got=%h exp=0", sp_color_idx); end
        total++; if (sp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", sp_valid); end
        total++; if (sp_zero !== 1'b0) begin bad++; $display("FAIL midrst_zero got=%b exp=0", sp_zero); end
        for (int d = 16; d < 256; d++) begin
            pix_en = 1'b1;
            tick();
            total++; if (sp_color_idx !== 4'h0) begin bad++; $display("FAIL midrst_post dot=%0d got=%h exp=0", d, sp_color_idx); end
        end
        pix_en = 1'b0;
    endtask

    task automatic test_slots16();
        logic [3:0] e;
        do_reset();
        load(15, 1'b1, 8'd5, 8'h03, 8'hFF, 8'h00, 1'b0);
        run_line();
        for (int d = 0; d < 20; d++) begin
            e = (d >= 5 && d <= 12) ? 4'hD : 4'h0;
            total++; if (g16[d] !== e) begin bad++; $display("FAIL slot15 dot=%0d got=%h exp=%h", d, g16[d], e); end
            total++; if (gc[d] !== 4'h0) begin bad++; $display("FAIL slot15_other dot=%0d got=%h exp=0", d, gc[d]); end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_flip();
        test_priority();
        test_zero_clip();
        test_sp_disable();
        test_truncation();
        test_back_to_back();
        test_reset_midline();
        test_slots16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
